// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size encoding, FSM states and
// the default split point between data memory and IO space.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'd0,
    SIZE_HALF    = 2'd1,
    SIZE_WORD    = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DM_RESP  = 3'd1,
    IO_WAIT  = 3'd2,
    IO_RESP  = 3'd3,
    ERR_RESP = 3'd4
  } state_e;

  localparam logic [15:0] DM_LIMIT_DEFAULT = 16'h3000;

  // Lane mask for an access; an illegal size touches no lanes.
  function automatic logic [3:0] byte_enables(input size_e size, input logic [1:0] low);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << low;
      SIZE_HALF: be = 4'b0011 << low;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Right-justifies a loaded word by its byte offset and sign/zero-extends it
// to 32 bits; used for both data memory and IO read data.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  low_addr_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  assign shifted = data_i >> {low_addr_i, 3'b000};

  always_comb begin
    result_o = shifted;
    case (size_i)
      SIZE_BYTE: result_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: result_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      default:   result_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_access.sv
// Load/store access unit: steers aligned requests to a single-cycle data RAM
// or to a handshaked IO bridge with timeout, and reports misalignment errors.
module lsu_access
  import lsu_pkg::*;
#(
  parameter logic [15:0] DM_LIMIT   = DM_LIMIT_DEFAULT,
  parameter int          DM_AW      = 12,
  parameter int          IO_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_misalign,
  output logic             resp_buserr,
  output logic             dm_en,
  output logic [3:0]       dm_we,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_wdata,
  input  logic [31:0]      dm_rdata,
  output logic             io_req,
  output logic             io_we,
  output logic [29:0]      io_addr,
  output logic [3:0]       io_be,
  output logic [31:0]      io_wdata,
  input  logic [31:0]      io_rdata,
  input  logic             io_ack
);

  localparam int CW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(IO_TIMEOUT - 1);

  state_e        state_q, state_d;
  size_e         size_q, size_d;
  logic          unsigned_q, unsigned_d;
  logic          we_q, we_d;
  logic [1:0]    low_q, low_d;
  logic          misalign_q, misalign_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          io_req_q, io_req_d;
  logic          io_we_q, io_we_d;
  logic [29:0]   io_addr_q, io_addr_d;
  logic [3:0]    io_be_q, io_be_d;
  logic [31:0]   io_wdata_q, io_wdata_d;
  logic [31:0]   io_rdata_q, io_rdata_d;

  size_e       req_size_e;
  logic [3:0]  req_be;
  logic [31:0] store_data;
  logic        misaligned;
  logic        is_dm;
  logic        accept;
  logic [31:0] ext_data;
  logic [31:0] ext_result;

  assign req_size_e = size_e'(req_size);
  assign req_be     = byte_enables(req_size_e, req_addr[1:0]);
  assign store_data = req_wdata << {req_addr[1:0], 3'b000};
  assign misaligned = (req_size_e == SIZE_ILLEGAL)
                    | ((req_size_e == SIZE_HALF) & req_addr[0])
                    | ((req_size_e == SIZE_WORD) & (|req_addr[1:0]));
  assign is_dm      = req_addr[15:0] < DM_LIMIT;

  assign req_ready = (state_q == IDLE) || (state_q == DM_RESP);
  // Reset gates acceptance so the RAM port stays quiet while rst is high.
  assign accept    = req_valid && req_ready && !rst;

  assign dm_en    = accept && !misaligned && is_dm;
  assign dm_we    = (dm_en && req_we) ? req_be : 4'b0000;
  assign dm_addr  = req_addr[DM_AW+1:2];
  assign dm_wdata = store_data;

  assign io_req   = io_req_q;
  assign io_we    = io_we_q;
  assign io_addr  = io_addr_q;
  assign io_be    = io_be_q;
  assign io_wdata = io_wdata_q;

  assign ext_data = (state_q == IO_RESP) ? io_rdata_q : dm_rdata;

  lsu_load_ext u_load_ext (
    .data_i     (ext_data),
    .low_addr_i (low_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .result_o   (ext_result)
  );

  assign resp_valid    = (state_q == DM_RESP) || (state_q == IO_RESP) || (state_q == ERR_RESP);
  assign resp_rdata    = (((state_q == DM_RESP) || (state_q == IO_RESP)) && !we_q) ? ext_result : 32'h0;
  assign resp_misalign = (state_q == ERR_RESP) && misalign_q;
  assign resp_buserr   = (state_q == ERR_RESP) && !misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      size_q     <= SIZE_BYTE;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      low_q      <= 2'b00;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
      io_req_q   <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= '0;
      io_be_q    <= 4'b0000;
      io_wdata_q <= 32'h0;
      io_rdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      we_q       <= we_d;
      low_q      <= low_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
      io_req_q   <= io_req_d;
      io_we_q    <= io_we_d;
      io_addr_q  <= io_addr_d;
      io_be_q    <= io_be_d;
      io_wdata_q <= io_wdata_d;
      io_rdata_q <= io_rdata_d;
    end
  end

  // An ack on the last allowed wait cycle takes priority over the timeout.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    we_d       = we_q;
    low_d      = low_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    io_req_d   = io_req_q;
    io_we_d    = io_we_q;
    io_addr_d  = io_addr_q;
    io_be_d    = io_be_q;
    io_wdata_d = io_wdata_q;
    io_rdata_d = io_rdata_q;
    case (state_q)
      IDLE, DM_RESP: begin
        state_d = IDLE;
        if (accept) begin
          size_d     = req_size_e;
          unsigned_d = req_unsigned;
          we_d       = req_we;
          low_d      = req_addr[1:0];
          if (misaligned) begin
            state_d    = ERR_RESP;
            misalign_d = 1'b1;
          end else if (is_dm) begin
            state_d = DM_RESP;
          end else begin
            state_d    = IO_WAIT;
            cnt_d      = '0;
            io_req_d   = 1'b1;
            io_we_d    = req_we;
            io_addr_d  = req_addr[31:2];
            io_be_d    = req_be;
            io_wdata_d = store_data;
          end
        end
      end
      IO_WAIT: begin
        if (io_ack) begin
          io_rdata_d = io_rdata;
          io_req_d   = 1'b0;
          state_d    = IO_RESP;
        end else if (cnt_q == CNT_LAST) begin
          io_req_d   = 1'b0;
          misalign_d = 1'b0;
          state_d    = ERR_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IO_RESP, ERR_RESP: state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_access.sv
// Randomized self-checking bench for lsu_access: a byte-level memory model and
// a per-cycle response scoreboard, plus directed cases with literal results.
module tb_lsu_access;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_buserr;
  logic        dm_en;
  logic [3:0]  dm_we;
  logic [11:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata = 32'h0;
  logic        io_req;
  logic        io_we;
  logic [29:0] io_addr;
  logic [3:0]  io_be;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata = 32'h0;
  logic        io_ack = 1'b0;

  always #5 clk = ~clk;

  lsu_access #(.DM_LIMIT(16'h3000), .DM_AW(12), .IO_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign), .resp_buserr(resp_buserr),
    .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_be(io_be),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        mis;
    logic        berr;
  } resp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          started = 1'b0;
  resp_t       expQ[$];
  logic [31:0] ram [4096];
  logic [7:0]  mdl [16384];

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM stand-in driven purely by the DUT's port.
  always @(posedge clk) begin
    if (dm_en) begin
      dm_rdata <= ram[dm_addr];
      for (int i = 0; i < 4; i++)
        if (dm_we[i]) ram[dm_addr][8*i +: 8] <= dm_wdata[8*i +: 8];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Every cycle: a response is either due now (and must match) or absent.
  always @(negedge clk) begin
    if (started) begin
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        resp_t e;
        e = expQ.pop_front();
        checkOutput("respValid", 32'(resp_valid), 32'd1);
        checkOutput("respRdata", resp_rdata, e.rdata);
        checkOutput("respMisalign", 32'(resp_misalign), 32'(e.mis));
        checkOutput("respBuserr", 32'(resp_buserr), 32'(e.berr));
      end else begin
        checkOutput("respIdle", 32'(resp_valid), 32'd0);
      end
    end
  end

  function automatic int nBytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit isMis(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] expMask(input logic [1:0] size, input int off);
    logic [3:0] m;
    m = 4'b0000;
    for (int i = 0; i < nBytes(size); i++) m[off+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input int n, input logic uns);
    logic [31:0] r;
    r = raw;
    if (n < 4)
      for (int i = 8*n; i < 32; i++) r[i] = uns ? 1'b0 : raw[8*n-1];
    return r;
  endfunction

  function automatic logic [31:0] dmLoad(input logic [31:0] addr, input logic [1:0] size, input logic uns);
    logic [31:0] raw;
    int base;
    raw = 32'h0;
    base = int'(addr[13:0]);
    for (int i = 0; i < nBytes(size); i++) raw[8*i +: 8] = mdl[base+i];
    return extend(raw, nBytes(size), uns);
  endfunction

  function automatic logic [31:0] ioLoad(input logic [31:0] word, input int off, input logic [1:0] size, input logic uns);
    logic [31:0] raw;
    raw = 32'h0;
    for (int i = 0; i < nBytes(size); i++) raw[8*i +: 8] = word[8*(off+i) +: 8];
    return extend(raw, nBytes(size), uns);
  endfunction

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  task automatic doDm(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit useLit, input logic [31:0] lit);
    resp_t e;
    int off, n, base;
    bit mis;
    off = int'(addr[1:0]);
    n = nBytes(size);
    base = int'(addr[13:0]);
    mis = isMis(size, addr);
    applyStimulus(we, size, uns, addr, wdata);
    io_ack = 1'($urandom_range(0, 1));
    io_rdata = $urandom;
    @(negedge clk);
    checkOutput("dmReady", 32'(req_ready), 32'd1);
    if (mis) begin
      checkOutput("misDmEn", 32'(dm_en), 32'd0);
      checkOutput("misIoReq", 32'(io_req), 32'd0);
    end else begin
      checkOutput("dmEn", 32'(dm_en), 32'd1);
      checkOutput("dmWe", 32'(dm_we), we ? 32'(expMask(size, off)) : 32'd0);
      checkOutput("dmAddr", 32'(dm_addr), 32'(addr[13:2]));
      if (we)
        for (int i = 0; i < n; i++)
          checkOutput("dmWdata", 32'(dm_wdata[8*(off+i) +: 8]), 32'(wdata[8*i +: 8]));
    end
    e.cyc  = cyc + 1;
    e.mis  = mis;
    e.berr = 1'b0;
    e.rdata = (mis || we) ? 32'h0 : (useLit ? lit : dmLoad(addr, size, uns));
    expQ.push_back(e);
    if (!mis && we)
      for (int i = 0; i < n; i++) mdl[base+i] = wdata[8*i +: 8];
    @(posedge clk); #1;
    req_valid = 1'b0;
    io_ack = 1'b0;
    if (mis) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic doIo(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                      input logic [31:0] wdata, input int ackDelay, input logic [31:0] ioData);
    resp_t e;
    int off, k;
    bit ack;
    off = int'(addr[1:0]);
    applyStimulus(we, size, uns, addr, wdata);
    io_ack = 1'b0;
    @(negedge clk);
    k = cyc;
    checkOutput("ioReady", 32'(req_ready), 32'd1);
    checkOutput("ioDmEn", 32'(dm_en), 32'd0);
    checkOutput("ioReqAccept", 32'(io_req), 32'd0);
    if (isMis(size, addr)) begin
      e.cyc = k + 1; e.rdata = 32'h0; e.mis = 1'b1; e.berr = 1'b0;
      expQ.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("ioMisReq", 32'(io_req), 32'd0);
      @(posedge clk); #1;
      return;
    end
    ack = (ackDelay >= 1 && ackDelay <= T);
    e.mis = 1'b0;
    if (ack) begin
      e.cyc = k + ackDelay + 1; e.berr = 1'b0;
      e.rdata = we ? 32'h0 : ioLoad(ioData, off, size, uns);
    end else begin
      e.cyc = k + T + 1; e.berr = 1'b1; e.rdata = 32'h0;
    end
    expQ.push_back(e);
    @(posedge clk); #1;
    for (int w = 1; w <= T; w++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = $urandom_range(0, 32'h2FFF) & 32'hFFFF_FFFC;
      req_size  = 2'd2;
      io_ack    = (w == ackDelay);
      io_rdata  = (w == ackDelay) ? ioData : $urandom;
      @(negedge clk);
      checkOutput("ioReqHeld", 32'(io_req), 32'd1);
      checkOutput("ioAddr", 32'(io_addr), 32'(addr[31:2]));
      checkOutput("ioBe", 32'(io_be), 32'(expMask(size, off)));
      checkOutput("ioWe", 32'(io_we), 32'(we));
      checkOutput("waitReady", 32'(req_ready), 32'd0);
      checkOutput("waitDmEn", 32'(dm_en), 32'd0);
      if (we)
        for (int i = 0; i < nBytes(size); i++)
          checkOutput("ioWdata", 32'(io_wdata[8*(off+i) +: 8]), 32'(wdata[8*i +: 8]));
      @(posedge clk); #1;
      if (w == ackDelay) break;
    end
    io_ack = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("ioReqDropped", 32'(io_req), 32'd0);
    checkOutput("respReady", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a, w;
    logic [1:0]  s;
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    for (int i = 0; i < 16384; i++) mdl[i] = 8'h0;

    // Reset with a live DM request: the RAM port must stay idle.
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h1234_5678);
    @(posedge clk); #1;
    started = 1'b1;
    @(negedge clk);
    checkOutput("rstDmEn", 32'(dm_en), 32'd0);
    checkOutput("rstDmWe", 32'(dm_we), 32'd0);
    checkOutput("rstIoReq", 32'(io_req), 32'd0);
    checkOutput("rstIoBe", 32'(io_be), 32'd0);
    checkOutput("rstIoAddr", 32'(io_addr), 32'd0);
    checkOutput("rstIoWdata", io_wdata, 32'd0);
    checkOutput("rstReady", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 1'b0;

    // Byte store then signed/unsigned byte loads.
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h0000_0102, 32'h0000_00A5);
    @(negedge clk);
    checkOutput("pinDmWe", 32'(dm_we), 32'h4);
    checkOutput("pinDmWdata", 32'(dm_wdata[23:16]), 32'hA5);
    begin
      resp_t e;
      e.cyc = cyc + 1; e.rdata = 32'h0; e.mis = 1'b0; e.berr = 1'b0;
      expQ.push_back(e);
    end
    mdl[16'h102] = 8'hA5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    doDm(1'b0, 2'd0, 1'b0, 32'h0000_0102, 32'h0, 1'b1, 32'hFFFF_FFA5);
    doDm(1'b0, 2'd0, 1'b1, 32'h0000_0102, 32'h0, 1'b1, 32'h0000_00A5);

    // Four word stores, then four back-to-back loads.
    for (int i = 0; i < 4; i++)
      doDm(1'b1, 2'd2, 1'b0, 32'h200 + 32'(4*i), 32'h1111_1111 * 32'(i+1), 1'b0, 32'h0);
    for (int i = 0; i < 4; i++)
      doDm(1'b0, 2'd2, 1'b0, 32'h200 + 32'(4*i), 32'h0, 1'b1, 32'h1111_1111 * 32'(i+1));

    doIo(1'b0, 2'd2, 1'b0, 32'h0000_7F00, 32'h0, 3, 32'h1234_5678);
    doIo(1'b1, 2'd2, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF, 0, 32'h0);
    doIo(1'b0, 2'd2, 1'b0, 32'h0000_4004, 32'h0, T, 32'hCAFE_F00D);
    doIo(1'b0, 2'd1, 1'b0, 32'h0000_4002, 32'h0, 1, 32'h8001_7FFF);

    doDm(1'b0, 2'd1, 1'b0, 32'h0000_0101, 32'h0, 1'b0, 32'h0);
    doDm(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 32'h0);
    doIo(1'b1, 2'd2, 1'b0, 32'h0000_5002, 32'h55AA_55AA, 1, 32'h0);

    // Reset in the middle of an IO wait abandons it silently.
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("preRstIoReq", 32'(io_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstIoReq", 32'(io_req), 32'd0);
    checkOutput("postRstReady", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    doDm(1'b0, 2'd2, 1'b0, 32'h0000_0204, 32'h0, 1'b1, 32'h2222_2222);

    for (int n = 0; n < 400; n++) begin
      s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      w = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        a = {16'($urandom), 16'($urandom_range(0, 16'h2FFF))};
        a[15:0] = a[15:0] & 16'h00FF;
        if ($urandom_range(0, 4) != 0) a[1:0] = (s == 2'd0) ? a[1:0] : (s == 2'd1) ? {a[1], 1'b0} : 2'b00;
        doDm(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, w, 1'b0, 32'h0);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end else begin
        a = {16'($urandom), 16'(32'h3000 + $urandom_range(0, 16'hCFFF))};
        if ($urandom_range(0, 4) != 0) a[1:0] = (s == 2'd0) ? a[1:0] : (s == 2'd1) ? {a[1], 1'b0} : 2'b00;
        doIo(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, w,
             $urandom_range(1, T + 2), $urandom);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_access.md
LSU_ACCESS -- requirements
Module: lsu_access

Interface
REQ-001 Parameter DM_LIMIT, default 16'h3000: addr[15:0] below this value selects data memory (DM); all other addresses select IO.
REQ-002 Parameter DM_AW, default 12: DM word-address width; dm_addr = addr[DM_AW+1:2].
REQ-003 Parameter IO_TIMEOUT, default 15: maximum cycles io_req waits for io_ack before a bus error.
REQ-004 Ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  access request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-justified.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_misalign  out  1  alignment or size error, valid with resp_valid.
- resp_buserr  out  1  IO timeout, valid with resp_valid.
- dm_en / dm_we / dm_addr / dm_wdata  out  1 / 4 / DM_AW / 32  synchronous RAM port, 1-cycle read latency.
- dm_rdata  in  32  RAM read data.
- io_req / io_we / io_addr / io_be / io_wdata  out  1 / 1 / 30 / 4 / 32  IO bridge request.
- io_rdata / io_ack  in  32 / 1  IO bridge response.

Function
REQ-005 Byte enables SHALL be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
REQ-006 Store data SHALL be placed at req_wdata<<{addr[1:0],3'b0} on dm_wdata and io_wdata.
REQ-007 Misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0, or size 3) SHALL cause no DM or IO side effect and SHALL produce resp_valid one cycle after accept with resp_misalign=1 and rdata=0.
REQ-008 FSM states SHALL be IDLE, DM_RESP, IO_WAIT, IO_RESP, ERR_RESP.
REQ-009 req_ready SHALL be 1 in IDLE and DM_RESP, and 0 in IO_WAIT, IO_RESP and ERR_RESP.
REQ-010 On accept of an aligned DM access, dm_en=1 and dm_we=(be if store, else 0) SHALL be driven combinationally in the accept cycle, with next state DM_RESP.
REQ-011 DM_RESP SHALL assert resp_valid; loads return dm_rdata>>{addr_q[1:0],3'b0}, then extended per size_q/unsigned_q; a new request may be accepted in the same cycle, giving 1 access/cycle throughput.
REQ-012 On accept of an aligned IO access, the next state SHALL be IO_WAIT; io_req=1 with io_addr=addr_q[31:2], io_we, io_be and io_wdata registered and held stable until exit.
REQ-013 io_ack in IO_WAIT SHALL capture io_rdata, go to IO_RESP and drop io_req on the next edge; IO_RESP asserts resp_valid with extended data, then returns to IDLE.
REQ-014 The wait counter SHALL clear on entering IO_WAIT; if the count reaches IO_TIMEOUT without io_ack, the FSM goes to ERR_RESP: resp_valid=1, resp_buserr=1, rdata=0, then IDLE.
REQ-015 io_ack arriving in the same cycle the count reaches IO_TIMEOUT SHALL win (normal completion).
REQ-016 io_ack outside IO_WAIT SHALL be ignored.
REQ-017 req_ready=0 SHALL leave req_* inputs unsampled.

Reset
REQ-018 On rst at a clock edge: state=IDLE, counter=0, all registered outputs 0 (resp_valid, resp_*, io_req, io_we, io_be, io_addr, io_wdata); reset during IO_WAIT SHALL abandon the transaction with no response.
REQ-019 dm_en and dm_we SHALL be 0 while rst=1.

Structure
REQ-020 Package lsu_pkg SHALL hold the size encoding enum, the FSM state enum and the DM_LIMIT default.
REQ-021 Load alignment and extension SHALL be a sub-module lsu_load_ext (inputs data, low_addr, size, unsigned; output 32-bit result), shared by the DM and IO paths.

Verification
REQ-022 Store byte 0xA5 at 0x0000_0102, then load byte signed -> dm_we=4'b0100, dm_wdata[23:16]=A5; load resp next cycle, rdata=0xFFFF_FFA5; unsigned load gives 0x0000_00A5.
REQ-023 Back-to-back DM loads on 4 consecutive cycles -> req_ready held 1, 4 resp_valid pulses on consecutive cycles, in order.
REQ-024 Load word at 0x0000_7F00 with io_ack after 3 cycles, io_rdata=0x1234_5678 -> io_req high 3 cycles, resp_valid 1 cycle after ack, rdata=0x1234_5678.
REQ-025 IO store with no io_ack -> resp_buserr=1 after IO_TIMEOUT cycles; also check ack on the exact boundary cycle completes normally.
REQ-026 Load half at 0x...01 and size=3 -> resp_misalign=1, dm_en=0, io_req=0.
REQ-027 rst asserted during IO_WAIT -> io_req=0 and state IDLE after the edge, no resp_valid; next request is served normally.
